// File: rtl/xor_cipher_if.sv
// Streaming word bus for the XOR cipher stage: plaintext/ciphertext and key in,
// transformed word out. No handshake; the producer drives new words every cycle.
interface xor_cipher_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] key;
   logic [WIDTH-1:0] data_out;

   modport master (
      output data_in,
      output key,
      input  data_out
   );

   modport slave (
      input  data_in,
      input  key,
      output data_out
   );
endinterface

// File: rtl/xor_cipher.sv
// Symmetric XOR cipher stage: data_out = data_in ^ key, delayed by LATENCY
// register stages. Encrypts and decrypts with the same key.
module xor_cipher #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   xor_cipher_if.slave  bus
);

   if (WIDTH < 1) begin : g_bad_width
      $error("xor_cipher: WIDTH must be at least 1");
   end

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("xor_cipher: LATENCY must be in the range 1..4");
   end

   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] stage_reg [LATENCY];

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign result[gi] = bus.data_in[gi] ^ bus.key[gi];
   end

   // Stage 0 captures the fresh XOR; later stages only shift, so after reset
   // release the first LATENCY-1 outputs are the zeros flushed through.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= result;
         for (int i = 1; i < LATENCY; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign bus.data_out = stage_reg[LATENCY-1];

endmodule

// File: tb/tb_xor_cipher.sv
// Self-checking bench for xor_cipher: three instances (8b/L1, 8b/L3, 16b/L2)
// checked against known vectors and a queue-based delayed-XOR model.
module tb_xor_cipher;

   localparam int L1  = 1;
   localparam int L3  = 3;
   localparam int L16 = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int tests_run = 0;
   int tests_failed = 0;

   xor_cipher_if #(.WIDTH(8))  if1 ();
   xor_cipher_if #(.WIDTH(8))  if3 ();
   xor_cipher_if #(.WIDTH(16)) if16 ();

   xor_cipher #(.WIDTH(8),  .LATENCY(L1))  u_l1  (.clk(clk), .rst(rst), .bus(if1));
   xor_cipher #(.WIDTH(8),  .LATENCY(L3))  u_l3  (.clk(clk), .rst(rst), .bus(if3));
   xor_cipher #(.WIDTH(16), .LATENCY(L16)) u_w16 (.clk(clk), .rst(rst), .bus(if16));

   always #5 clk = ~clk;

   // Reference: each queue holds the last LATENCY sampled results, oldest first;
   // the oldest entry is what data_out must show.
   logic [15:0] q1[$];
   logic [15:0] q3[$];
   logic [15:0] q16[$];

   typedef struct {
      logic [7:0] d;
      logic [7:0] k;
      logic [7:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q3.delete();
      q16.delete();
      repeat (L1)  q1.push_back(16'h0);
      repeat (L3)  q3.push_back(16'h0);
      repeat (L16) q16.push_back(16'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         q1.push_back({8'h00, if1.data_in ^ if1.key});
         q1.delete(0);
         q3.push_back({8'h00, if3.data_in ^ if3.key});
         q3.delete(0);
         q16.push_back(if16.data_in ^ if16.key);
         q16.delete(0);
      end
      #1;
      check("model_l1",  {8'h00, if1.data_out}, q1[0]);
      check("model_l3",  {8'h00, if3.data_out}, q3[0]);
      check("model_w16", if16.data_out, q16[0]);
   endtask

   task automatic async_reset_check(input string name);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      check({name, "_l1"},  {8'h00, if1.data_out}, 16'h0);
      check({name, "_l3"},  {8'h00, if3.data_out}, 16'h0);
      check({name, "_w16"}, if16.data_out, 16'h0);
      $display("[TB] %s: async reset, outputs %h %h %h", name, if1.data_out, if3.data_out, if16.data_out);
   endtask

   initial begin
      vec_t tbl[8];
      logic [7:0] l3_exp[7];

      tbl[0] = '{8'hAA, 8'h0F, 8'hA5};
      tbl[1] = '{8'h55, 8'hFF, 8'hAA};
      tbl[2] = '{8'h00, 8'h12, 8'h12};
      tbl[3] = '{8'hF0, 8'h0F, 8'hFF};
      tbl[4] = '{8'h3C, 8'h5A, 8'h66};
      tbl[5] = '{8'h66, 8'h5A, 8'h3C};
      tbl[6] = '{8'h7E, 8'h00, 8'h7E};
      tbl[7] = '{8'h7E, 8'hFF, 8'h81};
      l3_exp = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

      if1.data_in = 8'hAA;   if1.key = 8'h0F;
      if3.data_in = 8'hAA;   if3.key = 8'h0F;
      if16.data_in = 16'hAAAA; if16.key = 16'h0F0F;
      model_reset();
      #2 rst = 1'b0;

      // Held in reset with live inputs: outputs must stay zero.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", {8'h00, if1.data_out}, 16'h0);
         $display("[TB] reset hold cycle %0d: data_out %h", i, if1.data_out);
      end
      rst = 1'b1;

      // Known vectors through the single-stage instance.
      for (int i = 0; i < 8; i++) begin
         if1.data_in = tbl[i].d;
         if1.key     = tbl[i].k;
         tick();
         check("vector_l1", {8'h00, if1.data_out}, {8'h00, tbl[i].exp});
         $display("[TB] vec %0d: %h ^ %h -> %h (exp %h)", i, tbl[i].d, tbl[i].k, if1.data_out, tbl[i].exp);
      end

      async_reset_check("mid_reset_a");
      tick();
      rst = 1'b1;

      // Three-stage stream: two flushed zeros, then 11..15.
      for (int i = 0; i < 7; i++) begin
         if3.data_in = (i < 5) ? 8'(i + 1) : 8'h00;
         if3.key     = (i < 5) ? 8'h10 : 8'h00;
         tick();
         check("l3_stream", {8'h00, if3.data_out}, {8'h00, l3_exp[i]});
         $display("[TB] l3 stream %0d: data_out %h (exp %h)", i, if3.data_out, l3_exp[i]);
      end

      // Reset mid-stream must discard words still in flight.
      for (int i = 0; i < 3; i++) begin
         if3.data_in = 8'h21 + 8'(i);
         if3.key     = 8'h10;
         tick();
      end
      async_reset_check("mid_reset_b");
      tick();
      rst = 1'b1;
      if3.data_in = 8'h00;
      if3.key     = 8'h00;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("l3_flush", {8'h00, if3.data_out}, 16'h0);
         $display("[TB] l3 flush %0d: data_out %h", i, if3.data_out);
      end

      // Wide instance.
      if16.data_in = 16'hFFFF;
      if16.key     = 16'h0F0F;
      tick();
      tick();
      check("w16_vector", if16.data_out, 16'hF0F0);
      $display("[TB] w16: FFFF ^ 0F0F -> %h", if16.data_out);

      // Randomized run on all instances, with one asynchronous reset pulse.
      for (int c = 0; c < 1000; c++) begin
         if (c == 600) async_reset_check("rand_reset");
         if (c == 602) rst = 1'b1;
         if1.data_in  = 8'($urandom);
         if1.key      = 8'($urandom);
         if3.data_in  = 8'($urandom);
         if3.key      = 8'($urandom);
         if16.data_in = 16'($urandom);
         if16.key     = 16'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/xor_cipher.md
# xor_cipher

Byte-wide symmetric XOR cipher stage. Each clock it combines the `data_in` word with the `key` word bitwise and presents the result on a registered output. The same block both encrypts and decrypts: feeding ciphertext with the same key returns plaintext. It sits in the datapath as a simple streaming transform with no handshake; upstream holds or changes data every cycle and downstream samples `data_out` after the fixed latency.

## Interface
Parameters:
- `WIDTH`, default 8 — width of data, key and output words; legal range ≥1.
- `LATENCY`, default 1 — number of register stages from inputs to `data_out`; legal range 1..4. Values outside this range are a configuration error; flag them with an elaboration-time check.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — one clock; reset is asynchronous and active-low. `rst`=0 clears all state immediately; release is synchronous to the next rising edge.
- `data_in`  input  WIDTH  — plaintext or ciphertext word.
- `key`  input  WIDTH  — key word, sampled together with `data_in` on the same edge.
- `data_out`  output  WIDTH  — registered result, `data_in ^ key` delayed by `LATENCY` cycles.

## Operation
- Combinational core: `result[i] = data_in[i] XOR key[i]` for every bit `i`. No carries, no width growth; the result is exactly WIDTH bits.
- The result feeds a shift pipeline of `LATENCY` WIDTH-bit registers. `data_out` is the last stage.
- No enable and no valid signal. Every rising edge while `rst`=1 samples new inputs and advances the pipeline.
- Involution: the transform is its own inverse. `(d ^ k) ^ k == d` for all d and k.
- Special cases:
  - key = 0 → output equals input.
  - key = all-ones → output is the bitwise inverse of the input.
  - input = 0 → output equals key.
- No internal key storage. The key may change every cycle, and each output uses the key sampled in the same cycle as its data.
- X or Z on the inputs propagates to the output. No masking is required.

## Timing
- Reset:
  - While `rst`=0, every pipeline register and `data_out` reads all-zeros, asynchronously, without waiting for a clock edge.
  - Asserting `rst` mid-stream discards all in-flight words.
- Latency:
  - Inputs sampled at rising edge N appear on `data_out` right after edge N+LATENCY-1.
  - With LATENCY=1, `data_out` updates at the same edge that samples the inputs and holds for the full cycle.
- Throughput: one word per clock, fully pipelined, no bubbles.
- First edge after reset release:
  - The first stage loads the current inputs.
  - Later stages still shift out zeros, so the first LATENCY-1 post-reset outputs are zero.
- Input changes between edges have no effect on `data_out` until the next edge. The output is glitch-free because it comes straight from a flop.
- Reset asserted on the same edge as input sampling: reset wins, and the output stays zero.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 with `data_in`=8'hAA, `key`=8'h0F, toggling `clk`.
  - Required: `data_out`=8'h00 throughout.
  - Stimulus: assert `rst` low between clock edges while `data_out` is non-zero.
  - Required: `data_out` drops to 8'h00 immediately, before the next edge.
- Known vectors, LATENCY=1, one per cycle after release: `data_in`/`key` = AA/0F, 55/FF, 00/12, F0/0F.
  - Required: `data_out` = A5, AA, 12, FF respectively, each valid one edge after sampling.
- Involution:
  - Stimulus: feed `data_in`=8'h3C, `key`=8'h5A.
  - Required: result 8'h66.
  - Stimulus: feed 8'h66 with the same key.
  - Required: result 8'h3C.
- Identity and inversion:
  - `key`=8'h00 with `data_in`=8'h7E → 8'h7E.
  - `key`=8'hFF with `data_in`=8'h7E → 8'h81.
- Pipelining, LATENCY=3:
  - Stimulus: stream 8'h01..8'h05 with `key`=8'h10 on consecutive cycles after reset release.
  - Required: two zero outputs, then 11, 12, 13, 14, 15 on consecutive cycles.
  - Stimulus: assert reset mid-stream.
  - Required: all stages flush to zero.
- Width scaling, WIDTH=16:
  - Stimulus: `data_in`=16'hFFFF, `key`=16'h0F0F.
  - Required: 16'hF0F0.
  - Also required: a randomized run of 1000 cycles matches the reference model (delayed XOR).
